// File: rtl/hamming_enc_stream.sv
// hamming_enc_stream
// Byte-stream Hamming(7,4) encoder. Each accepted byte is split into two
// nibbles (low first); each nibble is presented as a registered 7-bit
// codeword on a valid/ready output. An optional per-byte error-injection
// position flips one codeword bit after parity generation so a downstream
// decoder's correction path can be exercised.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_data       byte to encode
//   in_valid      in_data is valid
//   in_ready      byte accepted this cycle (combinational from state/out_ready)
//   inj_pos       0: no injection, 1..7: flip codeword bit inj_pos-1
//   out_codeword  registered 7-bit codeword, bit i = Hamming position i+1
//   out_valid     out_codeword is valid
//   out_ready     downstream consumes the codeword this cycle
//   out_last      high while the high-nibble codeword is presented
//   cw_count      wrapping count of codewords handed off
module hamming_enc_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       inj_pos,
  output logic [6:0]       out_codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] cw_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] hi_nib;
  logic [2:0] inj_hold;
  logic       accept;
  logic       handoff;

  // Data bits sit at positions 3,5,6,7; parity at 1,2,4.
  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
            d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic logic [6:0] inject(input logic [6:0] cw, input logic [2:0] pos);
    logic [6:0] mask;
    mask = (pos == 3'd0) ? 7'd0 : (7'd1 << (pos - 3'd1));
    return cw ^ mask;
  endfunction

  // A new byte can enter when nothing is held, or when the final codeword
  // of the current byte leaves on this same edge (no bubble).
  assign in_ready = (state == EMPTY) || ((state == HIGH) && out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  // Held byte payload: only consulted while state != EMPTY, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      hi_nib   <= in_data[7:4];
      inj_hold <= inj_pos;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      out_codeword <= 7'd0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state        <= LOW;
            out_codeword <= inject(encode(in_data[3:0]), inj_pos);
            out_valid    <= 1'b1;
            out_last     <= 1'b0;
          end
        end
        LOW: begin
          if (out_ready) begin
            state        <= HIGH;
            out_codeword <= inject(encode(hi_nib), inj_hold);
            out_last     <= 1'b1;
          end
        end
        HIGH: begin
          if (out_ready) begin
            if (in_valid) begin
              state        <= LOW;
              out_codeword <= inject(encode(in_data[3:0]), inj_pos);
              out_valid    <= 1'b1;
              out_last     <= 1'b0;
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

  // Handoff counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_count <= '0;
    end else if (handoff) begin
      cw_count <= cw_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// tb_hamming_enc_stream
// Self-checking bench for hamming_enc_stream (instantiated with CNT_W=4 so
// counter wrap is reachable). A queue of expected codewords, filled from a
// positional Hamming encoder, predicts every output cycle.
module tb_hamming_enc_stream;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                rst_n;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          inj_pos;
  logic [6:0]          out_codeword;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [TB_CNT_W-1:0] cw_count;

  hamming_enc_stream #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inj_pos      (inj_pos),
    .out_codeword (out_codeword),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .cw_count     (cw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] cw;
    logic       lst;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;
  logic last_rdy;
  logic [6:0] obs[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Hamming by position: data at non-power-of-two positions, each parity
  // position p covers every position whose index has bit p set.
  function automatic logic [6:0] ref_enc(input logic [3:0] nib, input logic [2:0] inj);
    int         dpos[4];
    logic [7:1] w;
    logic       par;
    dpos = '{3, 5, 6, 7};
    w = '0;
    for (int k = 0; k < 4; k++) w[dpos[k]] = nib[k];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int j = 1; j <= 7; j++)
        if (((j & p) != 0) && (j != p)) par = par ^ w[j];
      w[p] = par;
    end
    if (inj != 3'd0) w[inj] = ~w[inj];
    return w[7:1];
  endfunction

  function automatic int syndrome(input logic [6:0] cw);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) if (cw[i]) s = s ^ (i + 1);
    return s;
  endfunction

  function automatic logic [3:0] recover(input logic [6:0] cw);
    logic [7:1] w;
    int         s;
    w = cw;
    s = syndrome(cw);
    if (s != 0) w[s] = ~w[s];
    return {w[7], w[6], w[5], w[3]};
  endfunction

  // One clock: check in_ready before the edge, advance the model at the
  // edge, then check all outputs against the head of the expected queue.
  task automatic cycle();
    logic       exp_rdy, hand, acc;
    logic [6:0] lo, hi;
    #1;
    exp_rdy = (q.size() == 0) || ((q.size() == 1) && out_ready);
    chk("in_ready", in_ready, exp_rdy);
    last_rdy = exp_rdy;
    hand = (q.size() != 0) && out_ready;
    acc  = in_valid && exp_rdy;
    lo = ref_enc(in_data[3:0], inj_pos);
    hi = ref_enc(in_data[7:4], inj_pos);
    @(posedge clk);
    if (hand) begin
      void'(q.pop_front());
      cnt = (cnt + 1) % (1 << TB_CNT_W);
    end
    if (acc) begin
      q.push_back('{cw: lo, lst: 1'b0});
      q.push_back('{cw: hi, lst: 1'b1});
    end
    #1;
    chk("cw_count", cw_count, cnt);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_codeword", out_codeword, q[0].cw);
      chk("out_last", out_last, q[0].lst);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; inj_pos = 3'd0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cw_count", cw_count, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_codeword", out_codeword, 7'h00);
    chk("rst_out_last", out_last, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single byte 0xA5
    in_data = 8'hA5; inj_pos = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("a5_lo_cw", out_codeword, 7'h2D);
    chk("a5_lo_last", out_last, 1'b0);
    cycle();
    chk("a5_hi_cw", out_codeword, 7'h52);
    chk("a5_hi_last", out_last, 1'b1);
    cycle();
    chk("a5_done_valid", out_valid, 1'b0);
    chk("a5_done_count", cw_count, 2);

    // Corner bytes back-to-back
    in_data = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    cycle(); obs[0] = out_codeword;
    chk("corner_rdy1", last_rdy, 1'b1);
    in_data = 8'hFF;
    cycle(); obs[1] = out_codeword;
    chk("corner_rdy2", last_rdy, 1'b0);
    cycle(); obs[2] = out_codeword;
    chk("corner_rdy3", last_rdy, 1'b1);
    in_valid = 1'b0;
    cycle(); obs[3] = out_codeword;
    chk("corner_valid4", out_valid, 1'b1);
    chk("corner_cw0", obs[0], 7'h00);
    chk("corner_cw1", obs[1], 7'h00);
    chk("corner_cw2", obs[2], 7'h7F);
    chk("corner_cw3", obs[3], 7'h7F);
    cycle();

    // Backpressure
    in_data = 8'hA5; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0; in_data = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_cw", out_codeword, 7'h2D);
      chk("bp_last", out_last, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_rel_cw", out_codeword, 7'h52);
    chk("bp_rel_last", out_last, 1'b1);
    cycle();

    // Error injection
    in_data = 8'hAA; inj_pos = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; inj_pos = 3'd0;
    for (int i = 0; i < 2; i++) begin
      chk("inj_cw", out_codeword, 7'h56);
      chk("inj_syn", syndrome(out_codeword), 3);
      chk("inj_nib", recover(out_codeword), 4'hA);
      cycle();
    end

    // Asynchronous reset mid-operation
    in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_cw_count", cw_count, 0);
    q.delete();
    cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("post_rst_idle", out_valid, 1'b0);

    // Counter wrap: 9 bytes streamed with no bubble
    in_valid = 1'b1; out_ready = 1'b1;
    for (int b = 0; b < 9; b++) begin
      in_data = 8'($urandom);
      cycle();
      if (b == 8) chk("wrap_to_zero", cw_count, 0);
      cycle();
      if (b == 7) chk("wrap_at_15", cw_count, 15);
    end
    in_valid = 1'b0;
    cycle();
    chk("wrap_final", cw_count, 2);
    chk("wrap_idle", out_valid, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      inj_pos   = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    chk("drain_idle", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_enc_stream.md
# hamming_enc_stream

Byte-stream Hamming(7,4) encoder that feeds the team's Hamming(7,4) decoder stage. It accepts bytes over a valid/ready handshake and splits each byte into two nibbles, low nibble first. Each nibble is emitted as a registered 7-bit codeword on a second valid/ready handshake. Optional single-bit error injection lets the downstream decoder's correction path be exercised in-system.

## Interface

Parameters:
- CNT_W, 16: width of the emitted-codeword counter.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  8  byte to encode.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- inj_pos  in  3  error-injection position, sampled with the byte. 0 means no injection; 1..7 means flip codeword bit inj_pos-1.
- out_codeword  out  7  encoded nibble, registered.
- out_valid  out  1  out_codeword is valid.
- out_ready  in  1  downstream consumes the codeword this cycle.
- out_last  out  1  high while the high-nibble codeword of a byte is presented.
- cw_count  out  CNT_W  number of codewords handed off; wraps.

## Operation

- Codeword layout: bit i is Hamming position i+1.
  - Data bits: c[2]=d0, c[4]=d1, c[5]=d2, c[6]=d3.
  - Parity bits: c[0]=d0^d1^d3, c[1]=d0^d2^d3, c[3]=d1^d2^d3.
  - With this layout, the syndrome {c3^c4^c5^c6, c1^c2^c5^c6, c0^c2^c4^c6} of a clean codeword is 0.
- Injection: when the registered inj_pos is nonzero, bit inj_pos-1 is inverted after parity generation. This applies to both codewords of that byte.
- FSM states:
  - EMPTY: no byte held.
  - LOW: low-nibble codeword presented.
  - HIGH: high-nibble codeword presented.
- Transitions:
  - EMPTY, in_valid → LOW. Register the byte and inj_pos; load the low-nibble codeword.
  - LOW, out_ready → HIGH. Load the high-nibble codeword.
  - LOW, !out_ready → hold LOW.
  - HIGH, out_ready and in_valid → LOW with the new byte (back-to-back, no bubble).
  - HIGH, out_ready and !in_valid → EMPTY.
  - HIGH, !out_ready → hold HIGH.
- in_ready = (state==EMPTY) | (state==HIGH & out_ready). It is combinational from state and out_ready.
- out_valid = (state!=EMPTY). out_last = (state==HIGH).
- Stability: while out_valid & !out_ready, out_codeword, out_last and out_valid are held unchanged.
- in_data and inj_pos are ignored whenever in_ready is low.
- cw_count increments by 1 on each cycle with out_valid & out_ready, wrapping from 2^CNT_W-1 to 0.

## Timing

- Reset (asynchronous, rst_n low): state=EMPTY, out_codeword=0, out_valid=0, out_last=0, cw_count=0, in_ready=1 (derived from state). Held bytes are discarded.
- Reset deassertion mid-operation: resume from EMPTY. No partial byte is emitted.
- Latency: a byte accepted at rising edge N presents its low codeword from edge N. The high codeword follows at the first edge with out_ready=1 after N.
- Throughput: 1 byte per 2 cycles when out_ready is held high and in_valid is held high.
- Simultaneous events: a HIGH-state handoff and a new-byte accept on the same edge are legal and required. cw_count increments once on that edge.
- No combinational path from in_valid or in_data to any output other than through registers. in_ready depends combinationally on out_ready only.

## Test plan

- Reset state: assert rst_n=0 asynchronously mid-cycle. Required: out_valid=0, cw_count=0, and in_ready=1 immediately, without waiting for a clock edge.
- Single byte: in_data=0xA5, inj_pos=0, out_ready=1. Required: out_codeword 0x2D with out_last=0, then 0x52 with out_last=1, then out_valid=0; cw_count=2.
- Corner bytes: 0x00 then 0xFF back-to-back, in_valid and out_ready held high. Required: codewords 0x00, 0x00, 0x7F, 0x7F on 4 consecutive cycles with no bubble; in_ready high on cycles 1 and 3.
- Backpressure: send 0xA5 and hold out_ready=0 for 5 cycles after accept. Required: out_codeword stays 0x2D, out_last=0, in_ready=0 throughout. After release the sequence is 0x2D, 0x52.
- Error injection: in_data=0xAA, inj_pos=3. Required: both codewords 0x56 (0x52 with bit 2 flipped). Decoder syndrome = 3 and the recovered nibble is 0xA on each.
- Counter wrap: CNT_W=4; stream 8 bytes then 1 more. Required: cw_count goes 15→0 on the 16th handoff and reads 2 after the 9th byte.
